// File: rtl/bobatc_pkg.sv
// bobatc shared types and constants for the UART and command path.
package bobatc_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 217;
  localparam int CMD_W = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/bobatc_sync2.sv
// bobatc two-flop synchronizer with selectable reset value.
module bobatc_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bobatc_uart_rx.sv
// bobatc UART 8N1 receiver; BOBATC_UART_RX_MAJORITY_EN enables 3-tap sample voting.
module bobatc_uart_rx
  import bobatc_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx,
  output logic [CMD_W-1:0] data,
  output logic             data_valid,
  output logic             framing_error,
  output logic             receiving
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  uart_rx_state_t   state;
  logic [CW-1:0]    cnt;
  logic [2:0]       idx;
  logic [CMD_W-1:0] shreg;
  logic             rx_s;
  logic             smp;
  logic             bit_end;

  bobatc_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

`ifdef BOBATC_UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) hist <= 2'b11;
    else        hist <= {hist[0], rx_s};
  end

  // vote window ends on the nominal sample so timing is unchanged
  assign smp = maj3(hist[1], hist[0], rx_s);
`else
  assign smp = rx_s;
`endif

  assign receiving = (state != RX_IDLE);
  assign bit_end   = (cnt == BIT_M1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= RX_IDLE;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            idx   <= '0;
            state <= smp ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (bit_end) begin
            cnt        <= '0;
            shreg[idx] <= smp;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (smp) begin
              data          <= shreg;
              data_valid    <= 1'b1;
              framing_error <= 1'b0;
              state         <= RX_IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= RX_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_BREAK: begin
          // a held-low line must not decode as 0x00 frames
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule
